// File: rtl/oled_pkg.sv
// Shared constants and state encoding for the SSD1306 text path.
// The panel geometry constants set the feeder's line length and line count.
package oled_pkg;

  localparam int OLED_COLS  = 128;
  localparam int OLED_PAGES = 4;
  localparam int GLYPH_W    = 8;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_NL    = 7'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_GAP,
    ST_PAD,
    ST_CLEAR
  } feeder_state_t;

endpackage

// File: rtl/oled_char_fifo.sv
// Synchronous character FIFO with registered full/empty flags.
// The head entry is readable without a pop, so a pop and its data share one cycle.
module oled_char_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_next;

  // A push into a full FIFO or a pop from an empty one is discarded.
  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == (AW+1)'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/oled_text_feeder.sv
// Feeds buffered ASCII codes to the SSD1306 controller one char at a time,
// tracking the cursor and expanding newline / clear into runs of spaces.
module oled_text_feeder
  import oled_pkg::*;
#(
  parameter int         FIFO_DEPTH     = 16,
  parameter int         CHARS_PER_LINE = OLED_COLS / GLYPH_W,
  parameter int         LINES          = OLED_PAGES,
  parameter logic [6:0] SPACE_CODE     = ASCII_SPACE,
  parameter logic [6:0] NEWLINE_CODE   = ASCII_NL
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       clear_req,
  output logic       busy,
  output logic [6:0] send_data,
  output logic       send_data_valid,
  input  logic       send_done,
  output logic [3:0] cur_col,
  output logic [1:0] cur_line
);

  localparam logic [3:0] COL_LAST    = 4'(CHARS_PER_LINE - 1);
  localparam logic [1:0] LINE_LAST   = 2'(LINES - 1);
  localparam logic [6:0] CLEAR_TOTAL = 7'(LINES * CHARS_PER_LINE);

  feeder_state_t r_state;
  logic [6:0]    r_send_data;
  logic [3:0]    r_col;
  logic [1:0]    r_line;
  logic          r_clear_pending;
  logic [6:0]    r_clear_cnt;
  logic          r_pad_active;

  feeder_state_t w_state_next;
  logic [6:0]    w_send_data_next;
  logic [3:0]    w_col_next;
  logic [1:0]    w_line_next;
  logic          w_clear_pending_next;
  logic [6:0]    w_clear_cnt_next;
  logic          w_pad_next;
  logic          w_start_clear;

  logic [6:0]    w_fifo_data;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_pop;

  oled_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (7)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_wr_data (wr_data),
    .i_push    (wr_valid),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  always_comb begin
    w_state_next     = r_state;
    w_send_data_next = r_send_data;
    w_col_next       = r_col;
    w_line_next      = r_line;
    w_clear_cnt_next = r_clear_cnt;
    w_pad_next       = r_pad_active;
    w_pop            = 1'b0;
    w_start_clear    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_clear_pending) begin
          w_start_clear = 1'b1;
          w_state_next  = ST_CLEAR;
        end else if (!w_fifo_empty) begin
          w_state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        w_pop = 1'b1;
        if (w_fifo_data == NEWLINE_CODE) begin
          // A newline at column 0 already sits on a fresh line: nothing to pad.
          if (r_col != '0) begin
            w_pad_next   = 1'b1;
            w_state_next = ST_PAD;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_send_data_next = w_fifo_data;
          w_state_next     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (send_done) begin
          w_state_next = ST_GAP;
          if (r_col == COL_LAST) begin
            w_col_next  = '0;
            w_line_next = (r_line == LINE_LAST) ? '0 : r_line + 1'b1;
          end else begin
            w_col_next = r_col + 1'b1;
          end
          if (r_clear_cnt != '0) begin
            w_clear_cnt_next = r_clear_cnt - 1'b1;
          end
        end
      end

      ST_GAP: begin
        // A newly requested clear wins over leftover newline padding.
        w_pad_next = 1'b0;
        if (r_clear_cnt != '0) begin
          w_state_next = ST_CLEAR;
        end else if (r_clear_pending) begin
          w_start_clear = 1'b1;
          w_state_next  = ST_CLEAR;
        end else if (r_pad_active && (r_col != '0)) begin
          w_pad_next   = 1'b1;
          w_state_next = ST_PAD;
        end else begin
          w_state_next = ST_IDLE;
        end
      end

      ST_PAD, ST_CLEAR: begin
        w_send_data_next = SPACE_CODE;
        w_state_next     = ST_SEND;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_start_clear) begin
      w_clear_cnt_next = CLEAR_TOTAL;
    end
  end

  // Requests arriving while a clear is already counting fold into it.
  always_comb begin
    w_clear_pending_next = r_clear_pending;
    if (w_start_clear) begin
      w_clear_pending_next = 1'b0;
    end else if (clear_req && (r_clear_cnt == '0)) begin
      w_clear_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_send_data     <= '0;
      r_col           <= '0;
      r_line          <= '0;
      r_clear_pending <= 1'b0;
      r_clear_cnt     <= '0;
      r_pad_active    <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_send_data     <= w_send_data_next;
      r_col           <= w_col_next;
      r_line          <= w_line_next;
      r_clear_pending <= w_clear_pending_next;
      r_clear_cnt     <= w_clear_cnt_next;
      r_pad_active    <= w_pad_next;
    end
  end

  assign wr_ready        = ~w_fifo_full;
  assign busy            = (r_state != ST_IDLE) | ~w_fifo_empty | r_clear_pending;
  assign send_data       = r_send_data;
  assign send_data_valid = (r_state == ST_SEND);
  assign cur_col         = r_col;
  assign cur_line        = r_line;

endmodule

// File: tb/tb_oled_text_feeder.sv
// Directed bench for oled_text_feeder with a behavioural SSD1306 controller
// that answers each offer with a one-cycle send_done 20 cycles later.
`timescale 1ns/1ps
module tb_oled_text_feeder;

  localparam int N_DONE = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       clear_req = 1'b0;
  logic       busy;
  logic [6:0] send_data;
  logic       send_data_valid;
  logic       send_done = 1'b0;
  logic [3:0] cur_col;
  logic [1:0] cur_line;

  int n_checks = 0;
  int n_pass   = 0;
  bit hold     = 1'b0;
  bit inject   = 1'b0;
  int unstable = 0;
  int gap_err  = 0;

  logic [6:0] q_data[$];
  logic [3:0] q_col[$];
  logic [1:0] q_line[$];

  oled_text_feeder dut (
    .clock           (clock),
    .reset           (reset),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .clear_req       (clear_req),
    .busy            (busy),
    .send_data       (send_data),
    .send_data_valid (send_data_valid),
    .send_done       (send_done),
    .cur_col         (cur_col),
    .cur_line        (cur_line)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [6:0] qd(input int i);
    return (i < q_data.size()) ? q_data[i] : 7'h7F;
  endfunction
  function automatic logic [3:0] qc(input int i);
    return (i < q_col.size()) ? q_col[i] : 4'hF;
  endfunction
  function automatic logic [1:0] ql(input int i);
    return (i < q_line.size()) ? q_line[i] : 2'h3;
  endfunction

  // Controller model: logs each char with the cursor it was written at.
  initial begin : ctrl
    int  cnt;
    bit  prev_done;
    bit  prev_valid;
    logic [6:0] prev_data;
    cnt = 0; prev_done = 1'b0; prev_valid = 1'b0; prev_data = '0;
    forever begin
      @(negedge clock);
      if (prev_done && send_data_valid) gap_err++;
      if (prev_valid && send_data_valid && (send_data !== prev_data)) unstable++;
      prev_valid = send_data_valid;
      prev_data  = send_data;
      prev_done  = send_done;
      send_done  = 1'b0;
      if (reset || !send_data_valid || prev_done) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= N_DONE && !hold) begin
          send_done = 1'b1;
          cnt = 0;
          q_data.push_back(send_data);
          q_col.push_back(cur_col);
          q_line.push_back(cur_line);
        end
      end
      if (inject) begin
        send_done = 1'b1;
        inject = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; wr_valid = 1'b0; clear_req = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    q_data.delete(); q_col.delete(); q_line.delete();
    unstable = 0; gap_err = 0;
  endtask

  task automatic wr(input logic [6:0] c);
    @(negedge clock);
    wr_data = c; wr_valid = 1'b1;
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    @(negedge clock);
    while (busy && k < budget) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (!send_data_valid && k < budget) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_valid"}, 32'(send_data_valid), 32'd1);
  endtask

  task automatic check_hs(input string tag);
    check({tag, "_stable"}, 32'(unstable), 32'd0);
    check({tag, "_gap"}, 32'(gap_err), 32'd0);
  endtask

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int errs;

    // Reset state
    do_reset();
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_send_data", 32'(send_data), 32'h0);
    check("rst_valid", 32'(send_data_valid), 32'd0);
    check("rst_col", 32'(cur_col), 32'd0);
    check("rst_line", 32'(cur_line), 32'd0);

    // 1: two chars in order
    wr(7'h41); wr(7'h42);
    check("t1_busy", 32'(busy), 32'd1);
    wait_idle("t1", 200);
    check("t1_count", 32'(q_data.size()), 32'd2);
    check("t1_d0", 32'(qd(0)), 32'h41);
    check("t1_d1", 32'(qd(1)), 32'h42);
    check("t1_c0", 32'(qc(0)), 32'd0);
    check("t1_c1", 32'(qc(1)), 32'd1);
    check("t1_col", 32'(cur_col), 32'd2);
    check("t1_line", 32'(cur_line), 32'd0);
    check_hs("t1");
    $display("t1 two chars: %0d offers, cursor (%0d,%0d)", q_data.size(), cur_line, cur_col);

    // 2: line wrap after 16 chars
    do_reset();
    for (int i = 0; i < 17; i++) wr(7'h41);
    wait_idle("t2", 17 * 30 + 100);
    check("t2_count", 32'(q_data.size()), 32'd17);
    errs = 0;
    for (int i = 0; i < 17; i++) if (qd(i) != 7'h41) errs++;
    check("t2_data", 32'(errs), 32'd0);
    check("t2_c15", 32'(qc(15)), 32'd15);
    check("t2_l15", 32'(ql(15)), 32'd0);
    check("t2_c16", 32'(qc(16)), 32'd0);
    check("t2_l16", 32'(ql(16)), 32'd1);
    check("t2_col", 32'(cur_col), 32'd1);
    check("t2_line", 32'(cur_line), 32'd1);
    check_hs("t2");
    $display("t2 wrap: %0d offers, cursor (%0d,%0d)", q_data.size(), cur_line, cur_col);

    // 3: newline padding
    do_reset();
    wr(7'h48); wr(7'h0A); wr(7'h49);
    wait_idle("t3", 17 * 30 + 100);
    check("t3_count", 32'(q_data.size()), 32'd17);
    check("t3_h", 32'(qd(0)), 32'h48);
    errs = 0;
    for (int i = 1; i < 16; i++)
      if (qd(i) != 7'h20 || qc(i) != 4'(i) || ql(i) != 2'd0) errs++;
    check("t3_pad", 32'(errs), 32'd0);
    check("t3_i", 32'(qd(16)), 32'h49);
    check("t3_i_col", 32'(qc(16)), 32'd0);
    check("t3_i_line", 32'(ql(16)), 32'd1);
    errs = 0;
    for (int i = 0; i < q_data.size(); i++) if (q_data[i] == 7'h0A) errs++;
    check("t3_no_nl", 32'(errs), 32'd0);
    check_hs("t3");
    $display("t3 newline: %0d offers, cursor (%0d,%0d)", q_data.size(), cur_line, cur_col);

    do_reset();
    wr(7'h0A);
    wait_idle("t3b", 50);
    check("t3b_count", 32'(q_data.size()), 32'd0);
    check("t3b_col", 32'(cur_col), 32'd0);
    check("t3b_line", 32'(cur_line), 32'd0);
    $display("t3b newline at col 0: %0d offers", q_data.size());

    // 4: FIFO full while controller stalls
    do_reset();
    hold = 1'b1;
    wr(7'h5A);
    wait_valid("t4", 50);
    check("t4_first", 32'(send_data), 32'h5A);
    for (int i = 0; i < 16; i++) begin
      wr(7'(8'h30 + i));
      if (i == 14) check("t4_ready15", 32'(wr_ready), 32'd1);
    end
    check("t4_full", 32'(wr_ready), 32'd0);
    wr(7'h40);
    check("t4_still_full", 32'(wr_ready), 32'd0);
    check("t4_held", 32'(send_data_valid), 32'd1);
    check("t4_none_out", 32'(q_data.size()), 32'd0);
    hold = 1'b0;
    begin
      int k = 0;
      while (!wr_ready && k < 60) begin
        @(negedge clock);
        k++;
      end
    end
    check("t4_ready_back", 32'(wr_ready), 32'd1);
    check("t4_ready_after1", 32'(q_data.size()), 32'd1);
    wait_idle("t4", 17 * 30 + 100);
    check("t4_count", 32'(q_data.size()), 32'd17);
    check("t4_d0", 32'(qd(0)), 32'h5A);
    errs = 0;
    for (int i = 1; i < 17; i++) if (qd(i) != 7'(8'h30 + i - 1)) errs++;
    check("t4_data", 32'(errs), 32'd0);
    check_hs("t4");
    $display("t4 full FIFO: %0d offers", q_data.size());

    // 5: clear mid-char, queued chars resume
    do_reset();
    wr(7'h58);
    wait_valid("t5", 50);
    @(negedge clock); clear_req = 1'b1;
    @(negedge clock); clear_req = 1'b0;
    wr(7'h59); wr(7'h5A);
    begin
      int k = 0;
      while (q_data.size() < 10 && k < 400) begin
        @(negedge clock);
        k++;
      end
    end
    check("t5_busy_mid", 32'(busy), 32'd1);
    @(negedge clock); clear_req = 1'b1;
    @(negedge clock); clear_req = 1'b0;
    wait_idle("t5", 67 * 30 + 200);
    check("t5_count", 32'(q_data.size()), 32'd67);
    check("t5_x", 32'(qd(0)), 32'h58);
    errs = 0;
    for (int k = 0; k < 64; k++)
      if (qd(1 + k) != 7'h20 || qc(1 + k) != 4'((1 + k) % 16) || ql(1 + k) != 2'(((1 + k) / 16) % 4)) errs++;
    check("t5_spaces", 32'(errs), 32'd0);
    check("t5_y", 32'(qd(65)), 32'h59);
    check("t5_y_col", 32'(qc(65)), 32'd1);
    check("t5_y_line", 32'(ql(65)), 32'd0);
    check("t5_z", 32'(qd(66)), 32'h5A);
    check("t5_col", 32'(cur_col), 32'd3);
    check("t5_line", 32'(cur_line), 32'd0);
    check_hs("t5");
    $display("t5 clear: %0d offers, cursor (%0d,%0d)", q_data.size(), cur_line, cur_col);

    // Stray send_done while idle
    inject = 1'b1;
    repeat (4) @(negedge clock);
    check("stray_col", 32'(cur_col), 32'd3);
    check("stray_line", 32'(cur_line), 32'd0);
    check("stray_valid", 32'(send_data_valid), 32'd0);
    $display("stray send_done: cursor (%0d,%0d)", cur_line, cur_col);

    // 6: reset mid-transfer
    do_reset();
    wr(7'h50);
    wait_idle("t6", 100);
    check("t6_col_pre", 32'(cur_col), 32'd1);
    wr(7'h51); wr(7'h52);
    wait_valid("t6", 50);
    check("t6_data", 32'(send_data), 32'h51);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    check("t6_valid", 32'(send_data_valid), 32'd0);
    check("t6_col", 32'(cur_col), 32'd0);
    check("t6_line", 32'(cur_line), 32'd0);
    check("t6_ready", 32'(wr_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("t6_quiet_valid", 32'(send_data_valid), 32'd0);
    check("t6_quiet_busy", 32'(busy), 32'd0);
    check("t6_count", 32'(q_data.size()), 32'd1);
    $display("t6 reset mid-char: %0d offers logged", q_data.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
